// File: rtl/pixel_link_pkg.sv
// pixel_link_pkg: shared types and control words for the bit-serial pixel link
package pixel_link_pkg;
  localparam logic [15:0] SOF_WORD = 16'h8000;
  localparam logic [15:0] EOL_WORD = 16'h8001;
  typedef enum logic {HUNT, RECV} state_t;
  typedef logic [15:0] pixel_word_t;
  typedef logic [14:0] rgb555_t;
  function automatic logic is_pixel(input pixel_word_t w);
    return !w[15];
  endfunction
endpackage

// File: rtl/pixel_stream_writer_if.sv
// pixel_stream_writer_if: serial link input plus frame buffer write port and status
interface pixel_stream_writer_if #(parameter int COL_BITS = 8, parameter int ROW_BITS = 8);
  import pixel_link_pkg::*;
  logic rx_bit;
  logic rx_bit_valid;
  logic [COL_BITS+ROW_BITS-1:0] wr_address;
  rgb555_t wr_data;
  logic wr_en;
  logic frame_active;
  logic frame_done;
  logic sync_lost;
  logic overflow_err;
  logic [7:0] frame_count;
  modport master (
    input rx_bit, rx_bit_valid,
    output wr_address, wr_data, wr_en, frame_active, frame_done, sync_lost, overflow_err, frame_count
  );
  modport slave (
    output rx_bit, rx_bit_valid,
    input wr_address, wr_data, wr_en, frame_active, frame_done, sync_lost, overflow_err, frame_count
  );
endinterface

// File: rtl/rx_word_deser.sv
// rx_word_deser: MSB-first shift register with word counter; word/strobe/match are
// combinational on the sampling cycle so the caller registers the action at that edge.
module rx_word_deser
  import pixel_link_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        rx_bit_valid,
  input  logic        align,
  output pixel_word_t word,
  output logic        word_stb,
  output logic        hunt_match
);
  logic [14:0] shift;
  logic [3:0]  bit_cnt;
  assign word       = {shift, rx_bit};
  assign word_stb   = rx_bit_valid && bit_cnt == 4'd15;
  assign hunt_match = rx_bit_valid && word == SOF_WORD;
  always_ff @(posedge clock)
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      if (rx_bit_valid) shift <= word[14:0];
      bit_cnt <= align ? 4'd0 : bit_cnt + 4'(rx_bit_valid);
    end
endmodule

// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer: locks onto SOF and writes deserialised pixels to the frame buffer
// at {col,row}; col carries one extra bit so a full line is distinguishable from wrap.
module pixel_stream_writer
  import pixel_link_pkg::*;
#(
  parameter int COL_BITS = 8,
  parameter int ROW_BITS = 8,
  parameter int TIMEOUT  = 1024
) (
  input logic clock,
  input logic reset,
  pixel_stream_writer_if.master bus
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [COL_BITS:0] col, col_n;
  logic [ROW_BITS-1:0] row, row_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0] count_n;
  logic [COL_BITS+ROW_BITS-1:0] address_n;
  rgb555_t data_n;
  logic we_n, done_n, lost_n, ovf_n;
  pixel_word_t word;
  logic word_stb, hunt_match;
  rx_word_deser deser (
    .clock(clock),
    .reset(reset),
    .rx_bit(bus.rx_bit),
    .rx_bit_valid(bus.rx_bit_valid),
    .align(state == HUNT),
    .word(word),
    .word_stb(word_stb),
    .hunt_match(hunt_match)
  );
  assign bus.frame_active = state == RECV;
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    timer_n   = '0;
    count_n   = bus.frame_count;
    address_n = bus.wr_address;
    data_n    = bus.wr_data;
    we_n      = 1'b0;
    done_n    = 1'b0;
    lost_n    = 1'b0;
    ovf_n     = 1'b0;
    if (state == HUNT) begin
      if (hunt_match) begin
        state_n = RECV;
        col_n   = '0;
        row_n   = '0;
      end
    end else if (!bus.rx_bit_valid) begin
      timer_n = timer + 1'b1;
      if (timer == TW'(TIMEOUT - 1)) begin
        timer_n = '0;
        lost_n  = 1'b1;
        state_n = HUNT;
      end
    end else if (word_stb) begin
      if (is_pixel(word)) begin
        we_n      = !col[COL_BITS];
        ovf_n     = col[COL_BITS];
        address_n = col[COL_BITS] ? bus.wr_address : {col[COL_BITS-1:0], row};
        data_n    = col[COL_BITS] ? bus.wr_data : word[14:0];
        col_n     = col[COL_BITS] ? col : col + 1'b1;
      end else if (word == EOL_WORD) begin
        if (row != '1) begin
          col_n = '0;
          row_n = row + 1'b1;
        end else begin
          done_n  = 1'b1;
          count_n = bus.frame_count + 8'd1;
          state_n = HUNT;
        end
      end else if (word == SOF_WORD) begin
        lost_n = col != '0 || row != '0;
        col_n  = '0;
        row_n  = '0;
      end else begin
        lost_n  = 1'b1;
        state_n = HUNT;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state            <= HUNT;
      col              <= '0;
      row              <= '0;
      timer            <= '0;
      bus.wr_address   <= '0;
      bus.wr_data      <= '0;
      bus.wr_en        <= 1'b0;
      bus.frame_done   <= 1'b0;
      bus.sync_lost    <= 1'b0;
      bus.overflow_err <= 1'b0;
      bus.frame_count  <= '0;
    end else begin
      state            <= state_n;
      col              <= col_n;
      row              <= row_n;
      timer            <= timer_n;
      bus.wr_address   <= address_n;
      bus.wr_data      <= data_n;
      bus.wr_en        <= we_n;
      bus.frame_done   <= done_n;
      bus.sync_lost    <= lost_n;
      bus.overflow_err <= ovf_n;
      bus.frame_count  <= count_n;
    end
endmodule

// File: tb/tb_pixel_stream_writer.sv
// tb_pixel_stream_writer: scoreboard bench; expected writes are queued as words are sent
module tb_pixel_stream_writer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int gap = 4;
  int tcol = 0;
  int trow = 0;
  int done_cnt = 0;
  int lost_cnt = 0;
  int ovf_cnt = 0;
  logic we_after;
  logic [30:0] sb[$];
  pixel_stream_writer_if bus ();
  pixel_stream_writer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (bus.wr_en) begin
      if (sb.size() == 0) chk("unexpected_write", {1'b0, bus.wr_address, bus.wr_data}, 32'hffffffff);
      else chk("write", {1'b0, bus.wr_address, bus.wr_data}, {1'b0, sb.pop_front()});
    end
    if (bus.wr_en || bus.frame_done || bus.sync_lost)
      chk("exclusive", 32'(bus.wr_en) + 32'(bus.frame_done) + 32'(bus.sync_lost), 1);
    if (bus.frame_done) done_cnt++;
    if (bus.sync_lost) lost_cnt++;
    if (bus.overflow_err) ovf_cnt++;
  end
  task automatic send_bit(input logic b);
    bus.rx_bit = b;
    bus.rx_bit_valid = 1'b1;
    @(posedge clock);
    #1;
    we_after = bus.wr_en;
    bus.rx_bit_valid = 1'b0;
    repeat (gap - 1) @(posedge clock);
    #1;
  endtask
  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask
  task automatic send_pix(input logic [14:0] d);
    if (tcol < 256) begin
      sb.push_back({tcol[7:0], trow[7:0], d});
      tcol++;
    end
    send_word({1'b0, d});
  endtask
  task automatic send_sof();
    tcol = 0;
    trow = 0;
    send_word(16'h8000);
  endtask
  task automatic send_eol();
    tcol = 0;
    trow++;
    send_word(16'h8001);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    bus.rx_bit = 1'b0;
    bus.rx_bit_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_we", bus.wr_en, 0);
    chk("rst_active", bus.frame_active, 0);
    chk("rst_count", bus.frame_count, 0);
    chk("rst_addr", bus.wr_address, 0);
    reset = 1'b0;
    send_sof();
    chk("t1_active", bus.frame_active, 1);
    send_pix(15'h7fff);
    chk("t1_latency", we_after, 1);
    send_pix(15'h001f);
    chk("t1_latency2", we_after, 1);
    send_eol();
    chk("t1_hold_addr", bus.wr_address, 32'h0100);
    chk("t1_hold_data", bus.wr_data, 32'h001f);
    send_word(16'h8123);
    chk("t5_bad_ctrl_lost", lost_cnt, 1);
    chk("t5_bad_ctrl_active", bus.frame_active, 0);
    send_word(16'h1234);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_sof();
    chk("t2_relock", bus.frame_active, 1);
    send_pix(15'h2aaa);
    repeat (1000) @(posedge clock);
    #1;
    chk("t5_no_early_timeout", lost_cnt, 1);
    repeat (30) @(posedge clock);
    #1;
    chk("t5_timeout_lost", lost_cnt, 2);
    chk("t5_timeout_active", bus.frame_active, 0);
    gap = 2;
    send_sof();
    for (int r = 0; r < 256; r++) begin
      if (r < 2 || r == 255)
        for (int c = 0; c < 4; c++) send_pix(15'(c ^ r));
      if (r == 255) chk("t3_no_early_done", done_cnt, 0);
      send_eol();
    end
    chk("t3_done", done_cnt, 1);
    chk("t3_count", bus.frame_count, 1);
    chk("t3_active_fall", bus.frame_active, 0);
    send_sof();
    for (int i = 0; i < 257; i++) send_pix(15'(i));
    chk("t4_overflow", ovf_cnt, 1);
    send_eol();
    send_pix(15'h0555);
    chk("t4_active", bus.frame_active, 1);
    chk("t4_lost_none", lost_cnt, 2);
    send_sof();
    chk("restart_lost", lost_cnt, 3);
    chk("restart_active", bus.frame_active, 1);
    send_pix(15'h7777);
    for (int i = 15; i > 8; i--) send_bit(i[0]);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_rst_addr", bus.wr_address, 0);
    chk("mid_rst_data", bus.wr_data, 0);
    chk("mid_rst_count", bus.frame_count, 0);
    chk("mid_rst_active", bus.frame_active, 0);
    chk("mid_rst_we", bus.wr_en, 0);
    reset = 1'b0;
    send_sof();
    chk("post_rst_active", bus.frame_active, 1);
    send_pix(15'h0123);
    repeat (4) @(posedge clock);
    #1;
    chk("sb_empty", sb.size(), 0);
    chk("done_total", done_cnt, 1);
    chk("ovf_total", ovf_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
